// File: rtl/uart_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared types and constants for the UART frame scheduler:
//               controller state encoding, byte-source phase encoding and
//               default sync header bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    // Controller states; the top FSM and the byte issuer share one encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_FETCH   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Source of the byte currently being sent
    typedef enum logic [1:0] {
        PH_HDR0 = 2'd0,
        PH_HDR1 = 2'd1,
        PH_PIX  = 2'd2,
        PH_CSUM = 2'd3
    } phase_e;

    localparam logic [7:0] c_SYNC0_DEFAULT = 8'hAA;
    localparam logic [7:0] c_SYNC1_DEFAULT = 8'h55;

endpackage
`default_nettype wire

// File: rtl/uart_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler_if
// Description : Pixel-pipeline, uart_send and frame status signals of the
//               frame scheduler. "master" is the scheduler itself, "slave"
//               is the surrounding pixel source / UART / frame control.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_scheduler_if;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_req;
    logic       uart_tx_busy;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;

    modport master (
        input  start, pix_valid, pix_data, uart_tx_busy,
        output pix_req, uart_en, uart_din, frame_busy, frame_done, overrun
    );

    modport slave (
        output start, pix_valid, pix_data, uart_tx_busy,
        input  pix_req, uart_en, uart_din, frame_busy, frame_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_scheduler_tx_byte_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tx_byte_issuer
// Description : One-byte uart_send handshake. A go pulse latches the byte,
//               strobes uart_en for one cycle, then tracks uart_tx_busy high
//               and low. done is a combinational pulse on the completing
//               cycle so the caller can chain the next byte with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_issuer
    import uart_frame_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       go,
    input  wire logic [7:0] byte_in,
    input  wire logic       uart_tx_busy,
    output logic            uart_en,
    output logic [7:0]      uart_din,
    output logic            done
);

    localparam logic [2:0] c_S_IDLE    = ST_IDLE;
    localparam logic [2:0] c_S_ISSUE   = ST_ISSUE;
    localparam logic [2:0] c_S_WAIT_HI = ST_WAIT_HI;
    localparam logic [2:0] c_S_WAIT_LO = ST_WAIT_LO;

    logic [2:0] r_state;
    logic [7:0] r_din;
    logic       w_load;

    // Byte completion and load qualification; a new byte may be loaded only when idle or on completion
    always_comb begin
        done     = (r_state == c_S_WAIT_LO) && !uart_tx_busy;
        w_load   = go && ((r_state == c_S_IDLE) || done);
        uart_en  = (r_state == c_S_ISSUE);
        uart_din = r_din;
    end

    // Handshake sequencer; the data register holds until the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_din   <= 8'h00;
        end else begin
            if (w_load) begin
                r_din <= byte_in;
            end
            case (r_state)
                c_S_IDLE:    if (go) r_state <= c_S_ISSUE;
                c_S_ISSUE:   r_state <= c_S_WAIT_HI;
                c_S_WAIT_HI: if (uart_tx_busy) r_state <= c_S_WAIT_LO;
                c_S_WAIT_LO: if (!uart_tx_busy) r_state <= go ? c_S_ISSUE : c_S_IDLE;
                default:     r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler
// Description : Sends one image frame over uart_send: SYNC0, SYNC1, then
//               IMG_W*IMG_H pixels each fetched with a pix_req pulse, then
//               an optional 8-bit modular checksum of the pixels.
//               Build option: UART_FRAME_CHKSUM_EN adds the checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int         IMG_W = 640,
    parameter int         IMG_H = 480,
    parameter logic [7:0] SYNC0 = c_SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1 = c_SYNC1_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    uart_frame_scheduler_if.master bus
);

    localparam int c_NPIX = IMG_W * IMG_H;
    localparam int c_CW   = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NPIX - 1);

    // ISSUE here means "a byte is owned by the issuer" (its ISSUE/WAIT_HI/WAIT_LO)
    localparam logic [2:0] c_S_IDLE  = ST_IDLE;
    localparam logic [2:0] c_S_ISSUE = ST_ISSUE;
    localparam logic [2:0] c_S_FETCH = ST_FETCH;
    localparam logic [2:0] c_S_DONE  = ST_DONE;

    logic [2:0]      r_state;
    phase_e          r_phase;
    logic [c_CW-1:0] r_cnt;
    logic            r_pix_req;
    logic            r_frame_busy;
    logic            r_frame_done;
    logic            r_overrun;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_go;
    logic [7:0]      w_byte;
    logic            w_done;
    logic            w_last;
    logic            w_uart_en;
    logic [7:0]      w_uart_din;

    tx_byte_issuer u_issuer (
        .clk          (clk),
        .rst          (rst),
        .go           (w_go),
        .byte_in      (w_byte),
        .uart_tx_busy (bus.uart_tx_busy),
        .uart_en      (w_uart_en),
        .uart_din     (w_uart_din),
        .done         (w_done)
    );

    // Choose the next byte and launch it in the same cycle it becomes known
    always_comb begin
        w_go   = 1'b0;
        w_byte = SYNC0;
        w_last = (r_cnt == c_LAST);
        case (r_state)
            c_S_IDLE: begin
                if (bus.start) begin
                    w_go   = 1'b1;
                    w_byte = SYNC0;
                end
            end
            c_S_FETCH: begin
                if (bus.pix_valid) begin
                    w_go   = 1'b1;
                    w_byte = bus.pix_data;
                end
            end
            c_S_ISSUE: begin
                if (w_done && (r_phase == PH_HDR0)) begin
                    w_go   = 1'b1;
                    w_byte = SYNC1;
                end
`ifdef UART_FRAME_CHKSUM_EN
                if (w_done && (r_phase == PH_PIX) && w_last) begin
                    w_go   = 1'b1;
                    w_byte = r_csum;
                end
`endif
            end
            default: ;
        endcase
    end

    // Frame sequencing: phase, pixel counter, checksum, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_phase      <= PH_HDR0;
            r_cnt        <= '0;
            r_pix_req    <= 1'b0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            r_pix_req    <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.pix_valid && (r_state != c_S_FETCH)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_phase      <= PH_HDR0;
                        r_state      <= c_S_ISSUE;
                        r_frame_busy <= 1'b1;
                        r_cnt        <= '0;
                        r_overrun    <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
                        r_csum       <= 8'h00;
`endif
                    end
                end
                c_S_ISSUE: begin
                    if (w_done) begin
                        case (r_phase)
                            PH_HDR0: r_phase <= PH_HDR1;
                            PH_HDR1: begin
                                r_phase   <= PH_PIX;
                                r_state   <= c_S_FETCH;
                                r_pix_req <= 1'b1;
                            end
                            PH_PIX: begin
                                if (!w_last) begin
                                    r_cnt     <= r_cnt + 1'b1;
                                    r_state   <= c_S_FETCH;
                                    r_pix_req <= 1'b1;
                                end else begin
`ifdef UART_FRAME_CHKSUM_EN
                                    r_phase      <= PH_CSUM;
`else
                                    r_state      <= c_S_DONE;
                                    r_frame_done <= 1'b1;
`endif
                                end
                            end
                            default: begin
                                r_state      <= c_S_DONE;
                                r_frame_done <= 1'b1;
                            end
                        endcase
                    end
                end
                c_S_FETCH: begin
                    if (bus.pix_valid) begin
                        r_state <= c_S_ISSUE;
`ifdef UART_FRAME_CHKSUM_EN
                        r_csum  <= r_csum + bus.pix_data;
`endif
                    end
                end
                c_S_DONE: begin
                    r_state      <= c_S_IDLE;
                    r_frame_busy <= 1'b0;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.pix_req    = r_pix_req;
    assign bus.uart_en    = w_uart_en;
    assign bus.uart_din   = w_uart_din;
    assign bus.frame_busy = r_frame_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_scheduler
// Description : Self-checking bench for uart_frame_scheduler on a 2x2 image.
//               A uart_send busy model and a pixel source answer the DUT;
//               expected byte streams are built from the frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_scheduler;

    localparam int         c_W        = 2;
    localparam int         c_H        = 2;
    localparam int         c_NPIX     = c_W * c_H;
    localparam int         c_BUSY_LEN = 8;
    localparam logic [7:0] c_SYNC0    = 8'hAA;
    localparam logic [7:0] c_SYNC1    = 8'h55;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_scheduler_if bus ();

    uart_frame_scheduler #(
        .IMG_W (c_W),
        .IMG_H (c_H),
        .SYNC0 (c_SYNC0),
        .SYNC1 (c_SYNC1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Written by the responder process only
    int         cyc = 0;
    int         busy_cnt = 0;
    logic [7:0] got_q[$];
    int         req_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         fall_cyc = -1;
    int         pend = -1;
    int         pend_idx = 0;
    int         inject_seen = 0;

    // Written by the stimulus process only
    logic [7:0] frame_pix [c_NPIX];
    int         req_base = 0;
    int         byte_base = 0;
    int         inject_seq = 0;
    bit         hold_off = 1'b0;

    // uart_send busy model, pixel source, overrun injector and monitors
    always @(negedge clk) begin
        cyc++;
        bus.pix_valid = 1'b0;
        if (bus.uart_en === 1'b1) begin
            got_q.push_back(bus.uart_din);
            busy_cnt = c_BUSY_LEN;
        end
        if (busy_cnt > 0 && !hold_off && got_q.size() > 0) begin
            check_eq("din_hold", bus.uart_din, got_q[got_q.size()-1]);
        end
        if (busy_cnt > 0) begin
            bus.uart_tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            if (bus.uart_tx_busy === 1'b1) fall_cyc = cyc;
            bus.uart_tx_busy = 1'b0;
        end
        if (bus.pix_req === 1'b1) begin
            pend_idx = req_cnt - req_base;
            req_cnt++;
            pend = int'($urandom_range(0, 3));
        end
        if (pend == 0) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = (pend_idx < c_NPIX) ? frame_pix[pend_idx] : 8'h00;
            pend = -1;
        end else if (pend > 0) begin
            pend--;
        end
        if (!bus.pix_valid && inject_seq != inject_seen && busy_cnt == 3 &&
            (got_q.size() - byte_base) >= 3) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'hEE;
            inject_seen   = inject_seq;
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_frame(input bit spurious, input bit do_inject, input bit do_reset);
        logic [7:0] exp_q[$];
        int         sum;
        int         db;
        int         t;
        bit         fin;
        t = 0;
        while (bus.uart_tx_busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        hold_off  = 1'b0;
        byte_base = got_q.size();
        req_base  = req_cnt;
        db        = done_cnt;
        if (do_inject) inject_seq++;

        // Reference frame: header, pixels, optional modular sum of pixels
        sum = 0;
        exp_q.push_back(c_SYNC0);
        exp_q.push_back(c_SYNC1);
        for (int i = 0; i < c_NPIX; i++) begin
            exp_q.push_back(frame_pix[i]);
            sum = (sum + int'(frame_pix[i])) % 256;
        end
`ifdef UART_FRAME_CHKSUM_EN
        exp_q.push_back(8'(sum));
`endif

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_to_en", bus.uart_en, 1);
        check_eq("sync0_din", bus.uart_din, c_SYNC0);
        check_eq("busy_set", bus.frame_busy, 1);
        check_eq("ovr_clr_on_start", bus.overrun, 0);

        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            bus.start = (spurious && c == 20);
            if (do_reset && (got_q.size() - byte_base) == 5 && busy_cnt == 4) begin
                rst      = 1'b1;
                hold_off = 1'b1;
                @(negedge clk);
                check_eq("rst_mid_en", bus.uart_en, 0);
                check_eq("rst_mid_fbusy", bus.frame_busy, 0);
                check_eq("rst_mid_din", bus.uart_din, 0);
                check_eq("rst_mid_req", bus.pix_req, 0);
                rst = 1'b0;
                return;
            end
            if (done_cnt != db) fin = 1'b1;
        end
        if (!fin) check_eq("frame_timeout", 0, 1);
        @(negedge clk);
        check_eq("busy_clr", bus.frame_busy, 0);
        check_eq("n_bytes", got_q.size() - byte_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (byte_base + i < got_q.size())
                check_eq($sformatf("byte%0d", i), got_q[byte_base+i], exp_q[i]);
        end
        check_eq("n_pix_req", req_cnt - req_base, c_NPIX);
        check_eq("n_done", done_cnt - db, 1);
        check_eq("done_latency", done_cyc - fall_cyc, 1);
        check_eq("overrun", bus.overrun, 32'(do_inject));
    endtask

    task automatic rand_pixels();
        for (int i = 0; i < c_NPIX; i++) frame_pix[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_en", bus.uart_en, 0);
        check_eq("rst_din", bus.uart_din, 0);
        check_eq("rst_req", bus.pix_req, 0);
        check_eq("rst_fbusy", bus.frame_busy, 0);
        check_eq("rst_fdone", bus.frame_done, 0);
        check_eq("rst_ovr", bus.overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        frame_pix = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_frame(1'b0, 1'b0, 1'b0);
        frame_pix = '{8'hFF, 8'hFF, 8'hFF, 8'h02};
        run_frame(1'b0, 1'b0, 1'b0);
        rand_pixels();
        run_frame(1'b0, 1'b1, 1'b0);
        rand_pixels();
        run_frame(1'b0, 1'b0, 1'b0);
        rand_pixels();
        run_frame(1'b1, 1'b0, 1'b0);
        rand_pixels();
        run_frame(1'b0, 1'b0, 1'b1);
        rand_pixels();
        run_frame(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rand_pixels();
            run_frame(1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Frame-level transmit controller that sits between the Gaussian filter output and `uart_send`. It sequences one image frame onto the serial link: two sync bytes, then IMG_W×IMG_H filtered pixels, then an optional checksum byte. It paces the pixel pipeline by issuing one `pix_req` pulse per pixel, and it drives the `uart_send` byte handshake from the `uart_tx_busy` edges.

## Interface
- `IMG_W`, default 640: pixels per line.
- `IMG_H`, default 480: lines per frame.
- `SYNC0`, default 8'hAA: first header byte.
- `SYNC1`, default 8'h55: second header byte.
- `clk` in 1: system clock. The block uses one clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: starts a frame. Sampled only in IDLE.
- `pix_valid` in 1: one-cycle strobe; a filtered pixel is present on `pix_data`.
- `pix_data` in 8: filtered pixel value.
- `pix_req` out 1: one-cycle pulse requesting the next pixel (drives matrix shift).
- `uart_tx_busy` in 1: busy flag from `uart_send`. It is in the `clk` domain.
- `uart_en` out 1: one-cycle byte-send strobe to `uart_send`.
- `uart_din` out 8: byte to send. Held stable from `uart_en` until `uart_tx_busy` falls.
- `frame_busy` out 1: high from `start` acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last byte completes.
- `overrun` out 1: sticky flag. Set by a `pix_valid` that arrives while not in FETCH. Cleared by `rst` or `start`.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, FETCH, DONE.
- A phase register selects the byte source: HDR0, HDR1, PIX, CSUM.
- IDLE:
  - `start`=1 → phase HDR0, `uart_din`←SYNC0, go to ISSUE.
  - `frame_busy`←1, pixel counter←0, checksum←0, `overrun`←0.
- ISSUE: `uart_en`=1 for exactly this cycle, then go to WAIT_HI.
- WAIT_HI: wait for `uart_tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: when `uart_tx_busy`=0, the byte is complete. The next state depends on phase:
  - HDR0 → `uart_din`←SYNC1, go to ISSUE.
  - HDR1 → phase PIX, go to FETCH.
  - PIX with pixel counter < IMG_W×IMG_H−1 → counter+1, go to FETCH.
  - PIX with last pixel → go to CSUM if the checksum is enabled, otherwise go to DONE.
  - CSUM → go to DONE.
- FETCH:
  - `pix_req`=1 on the first cycle only.
  - On `pix_valid`: `uart_din`←`pix_data`, checksum←checksum+`pix_data` (mod 256), go to ISSUE.
- DONE: `frame_done`=1 and `frame_busy`←0 for one cycle, then go to IDLE.
- Pixel counter width is $clog2(IMG_W×IMG_H). The counter saturates at the last index and never wraps within a frame.
- The checksum is the 8-bit modular sum of pixel bytes only. Sync bytes are excluded.

## Timing
- Reset values: all outputs 0, `uart_din`=8'h00, state IDLE, counters 0.
- `start` → `uart_en` (SYNC0): 1 cycle.
- `pix_valid` → `uart_en`: 1 cycle.
- `uart_tx_busy` fall → next `uart_en`: 1 cycle for header/checksum bytes.
- `uart_tx_busy` fall → `pix_req` (next pixel): 1 cycle.
- `pix_req` is issued for every pixel, including the first. There is no request after the last pixel.
- `start` while `frame_busy`=1 is ignored.
- `pix_valid` in the same cycle as `pix_req` is accepted.
- `pix_valid` outside FETCH: the data is dropped and `overrun`←1.
- `rst` mid-frame: return to IDLE on the next edge and clear all outputs. Any UART byte already in flight completes on its own and is not tracked.
- A stuck `uart_tx_busy` stalls the block in WAIT_HI or WAIT_LO. There is no timeout.

## Configuration
- `UART_FRAME_CHKSUM_EN` defined: the CSUM phase is compiled in, and one checksum byte is sent after the last pixel. The frame is IMG_W×IMG_H+3 bytes.
- `UART_FRAME_CHKSUM_EN` undefined: the checksum register and the CSUM phase are absent, and the last pixel goes directly to DONE. The frame is IMG_W×IMG_H+2 bytes.

## Structure
- Package `uart_frame_pkg` contains:
  - the state enum;
  - the phase enum;
  - default SYNC0/SYNC1 constants.
- Sub-module `tx_byte_issuer` implements the ISSUE/WAIT_HI/WAIT_LO handshake:
  - inputs: `go`, `byte`, `uart_tx_busy`;
  - outputs: `uart_en`, `uart_din`, `done` (one-cycle pulse).
- The top FSM handles the phase, FETCH, counters and checksum.

## Test plan
- IMG_W=2, IMG_H=2, pixels 10,20,30,40, busy model 8 cycles → bytes AA,55,0A,14,1E,28,64 (checksum with the macro), `frame_done` once, exactly 4 `pix_req` pulses.
- Same frame without the macro → 6 bytes, ending in 28. `frame_done` follows the 28 byte's busy fall by 1 cycle.
- Pixels FF,FF,FF,02 → checksum 8'hFF (wraps mod 256).
- Extra `pix_valid` during WAIT_LO → `overrun`=1, byte stream unchanged. A later `start` clears `overrun`.
- `rst` asserted in the third pixel's WAIT_LO → next cycle: IDLE, `uart_en`=0, `frame_busy`=0. A new `start` resends from AA.
- `start` pulsed while `frame_busy`=1 → ignored, no extra SYNC0.
